exec_operand_fwd: RTL

Parametrised successor to the execute-stage operand mux. Sits between register-file read and the ALU.
- Computes forwarding selects internally from a scoreboard of in-flight destinations, instead of taking external A/B select bits.
- Detects load-use hazards and stalls through a valid/ready handshake.
- Registers the ALU operands, store data and branch-compare flags into the EX pipeline register.

---
 rtl/exec_operand_fwd_pkg.sv | 30 +++
 rtl/exec_operand_fwd_if.sv | 58 +++++
 rtl/exec_operand_fwd_fwd_select.sv | 59 +++++
 rtl/exec_operand_fwd.sv | 106 ++++++++++
 4 files changed

// File: rtl/exec_operand_fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : exec_pkg
// Brief   : Shared types for the execute-stage operand forwarding block.
// Revision: 1.0 - initial release
// ============================================================================
package exec_pkg;

    localparam int c_XLEN_DEFAULT = 32;
    localparam int c_NREG_DEFAULT = 32;
    // Scoreboard rd field is sized for the widest supported register file.
    localparam int c_RD_W         = 8;

    typedef struct packed {
        logic [c_RD_W-1:0] rd;
        logic              we;
        logic              is_load;
    } sb_entry_t;

    typedef enum logic [2:0] {
        RF   = 3'd0,
        FWD0 = 3'd1,
        FWD1 = 3'd2,
        FWD2 = 3'd3,
        FWD3 = 3'd4,
        ZERO = 3'd5
    } fwd_sel_t;

endpackage
`default_nettype wire

// File: rtl/exec_operand_fwd_if.sv
`default_nettype none
// ============================================================================
// Module  : exec_operand_fwd_if
// Brief   : Issue, forwarding and EX-register bundle of the operand stage.
// Revision: 1.0 - initial release
// ============================================================================
interface exec_operand_fwd_if #(
    parameter int XLEN = 32,
    parameter int NFWD = 2,
    parameter int NREG = 32
);
    localparam int c_RAW = $clog2(NREG);

    logic                 in_valid;
    logic                 in_ready;
    logic [c_RAW-1:0]     in_rs1;
    logic [c_RAW-1:0]     in_rs2;
    logic [c_RAW-1:0]     in_rd;
    logic                 in_rd_we;
    logic                 in_is_load;
    logic                 in_a_pc;
    logic                 in_b_imm;
    logic                 in_brun;
    logic [XLEN-1:0]      in_pc;
    logic [XLEN-1:0]      in_imm;
    logic [XLEN-1:0]      rf_rs1;
    logic [XLEN-1:0]      rf_rs2;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic [NFWD-1:0]      fwd_valid;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      op_a;
    logic [XLEN-1:0]      op_b;
    logic [XLEN-1:0]      data_w;
    logic                 br_eq;
    logic                 br_lt;
    logic [c_RAW-1:0]     out_rd;
    logic                 out_rd_we;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_is_load, in_a_pc,
               in_b_imm, in_brun, in_pc, in_imm, rf_rs1, rf_rs2, fwd_data,
               fwd_valid, flush, out_ready,
        input  in_ready, out_valid, op_a, op_b, data_w, br_eq, br_lt, out_rd,
               out_rd_we
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_is_load, in_a_pc,
               in_b_imm, in_brun, in_pc, in_imm, rf_rs1, rf_rs2, fwd_data,
               fwd_valid, flush, out_ready,
        output in_ready, out_valid, op_a, op_b, data_w, br_eq, br_lt, out_rd,
               out_rd_we
    );

endinterface
`default_nettype wire

// File: rtl/exec_operand_fwd_fwd_select.sv
`default_nettype none
// ============================================================================
// Module  : fwd_select
// Brief   : Priority match of one source index against the scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module fwd_select
    import exec_pkg::*;
#(
    parameter int XLEN = c_XLEN_DEFAULT,
    parameter int NFWD = 2,
    parameter int RAW  = 5
) (
    input  wire logic [RAW-1:0]       src,
    input  wire logic [XLEN-1:0]      rf_val,
    input  wire sb_entry_t            sb [NFWD],
    input  wire logic [NFWD*XLEN-1:0] fwd_data,
    input  wire logic [NFWD-1:0]      fwd_valid,
    output logic      [XLEN-1:0]      val,
    output logic                      hazard
);
    localparam int c_IDX_W = (NFWD > 1) ? $clog2(NFWD) : 1;

    fwd_sel_t           w_sel;
    logic [c_IDX_W-1:0] w_idx;
    logic [XLEN-1:0]    w_fd [NFWD];

    // Descending scan so the youngest matching producer overrides older ones.
    always_comb begin
        w_sel = RF;
        w_idx = '0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            w_fd[k] = fwd_data[k*XLEN +: XLEN];
            if (sb[k].we && (sb[k].rd == c_RD_W'(src))) begin
                w_sel = fwd_sel_t'(3'(k + 1));
                w_idx = c_IDX_W'(k);
            end
        end
        if (src == '0) begin
            w_sel = ZERO;
        end
    end

    // A load one slot ahead has no result yet, whatever fwd_valid claims.
    always_comb begin
        val    = rf_val;
        hazard = 1'b0;
        case (w_sel)
            RF:      val = rf_val;
            ZERO:    val = '0;
            default: begin
                val    = w_fd[w_idx];
                hazard = !fwd_valid[w_idx] || ((w_idx == '0) && sb[w_idx].is_load);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/exec_operand_fwd.sv
`default_nettype none
// ============================================================================
// Module  : exec_operand_fwd
// Brief   : EX-stage operand mux with scoreboard forwarding and load-use stall.
// Revision: 1.0 - initial release
// ============================================================================
module exec_operand_fwd
    import exec_pkg::*;
#(
    parameter int XLEN = c_XLEN_DEFAULT,
    parameter int NFWD = 2,
    parameter int NREG = c_NREG_DEFAULT
) (
    input  wire logic           clk,
    input  wire logic           rst,
    exec_operand_fwd_if.slave   bus
);
    localparam int c_RAW = $clog2(NREG);

    sb_entry_t        r_sb [NFWD];
    logic             r_out_valid;
    logic [XLEN-1:0]  r_op_a;
    logic [XLEN-1:0]  r_op_b;
    logic [XLEN-1:0]  r_data_w;
    logic             r_br_eq;
    logic             r_br_lt;
    logic [c_RAW-1:0] r_out_rd;
    logic             r_out_rd_we;

    logic [XLEN-1:0]  w_rs1_val;
    logic [XLEN-1:0]  w_rs2_val;
    logic             w_haz_rs1;
    logic             w_haz_rs2;
    logic             w_advance;
    logic             w_accept;
    logic             w_br_lt;
    sb_entry_t        w_new_entry;

    fwd_select #(.XLEN(XLEN), .NFWD(NFWD), .RAW(c_RAW)) u_fwd_rs1 (
        .src(bus.in_rs1), .rf_val(bus.rf_rs1), .sb(r_sb),
        .fwd_data(bus.fwd_data), .fwd_valid(bus.fwd_valid),
        .val(w_rs1_val), .hazard(w_haz_rs1)
    );

    fwd_select #(.XLEN(XLEN), .NFWD(NFWD), .RAW(c_RAW)) u_fwd_rs2 (
        .src(bus.in_rs2), .rf_val(bus.rf_rs2), .sb(r_sb),
        .fwd_data(bus.fwd_data), .fwd_valid(bus.fwd_valid),
        .val(w_rs2_val), .hazard(w_haz_rs2)
    );

    assign w_advance = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_advance && !(w_haz_rs1 || w_haz_rs2) && !bus.flush;
    assign w_accept  = bus.in_valid && bus.in_ready;
    assign w_br_lt   = bus.in_brun ? (w_rs1_val < w_rs2_val)
                                   : ($signed(w_rs1_val) < $signed(w_rs2_val));

    always_comb begin
        w_new_entry = '0;
        if (w_accept) begin
            w_new_entry.rd      = c_RD_W'(bus.in_rd);
            w_new_entry.we      = bus.in_rd_we && (bus.in_rd != '0);
            w_new_entry.is_load = bus.in_is_load;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NFWD; k++) r_sb[k] <= '0;
            r_out_valid <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_data_w    <= '0;
            r_br_eq     <= 1'b0;
            r_br_lt     <= 1'b0;
            r_out_rd    <= '0;
            r_out_rd_we <= 1'b0;
        end else if (bus.flush) begin
            for (int k = 0; k < NFWD; k++) r_sb[k] <= '0;
            r_out_valid <= 1'b0;
            r_out_rd_we <= 1'b0;
        end else if (w_advance) begin
            // The oldest slot falls off: its result is already in the register file.
            for (int k = NFWD - 1; k > 0; k--) r_sb[k] <= r_sb[k-1];
            r_sb[0]     <= w_new_entry;
            r_out_valid <= w_accept;
            r_out_rd_we <= w_accept && bus.in_rd_we;
            r_op_a      <= bus.in_a_pc ? bus.in_pc : w_rs1_val;
            r_op_b      <= bus.in_b_imm ? bus.in_imm : w_rs2_val;
            r_data_w    <= w_rs2_val;
            r_br_eq     <= (w_rs1_val == w_rs2_val);
            r_br_lt     <= w_br_lt;
            r_out_rd    <= bus.in_rd;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.op_a      = r_op_a;
    assign bus.op_b      = r_op_b;
    assign bus.data_w    = r_data_w;
    assign bus.br_eq     = r_br_eq;
    assign bus.br_lt     = r_br_lt;
    assign bus.out_rd    = r_out_rd;
    assign bus.out_rd_we = r_out_rd_we;

endmodule
`default_nettype wire
